// File: rtl/alu_sequencer.sv
// alu_sequencer: 4-cycle issue/writeback stage around an external 16-bit ALU,
// with an 8x16 register file, MOVI immediate path and a debug read port.
module alu_sequencer #(
  parameter int DATA_W = 16,
  parameter int REG_N  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_num1,
  output logic [DATA_W-1:0] alu_num2,
  output logic [3:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  output logic              wb_valid,
  output logic [2:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              zero_flag,
  output logic              illegal,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
  state_t            state_q, state_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] rf_q [REG_N];
  logic [DATA_W-1:0] rf_d [REG_N];
  logic [DATA_W-1:0] num1_q, num1_d, num2_q, num2_d, result_q, result_d;
  logic [3:0]        opc_q, opc_d;
  logic              zero_q, zero_d;
  logic [3:0]        op;
  logic [2:0]        rd, rs1, rs2;
  logic [DATA_W-1:0] imm;
  logic              is_alu, is_movi, is_ill, in_wb, writes;
  assign op      = ir_q[15:12];
  assign rd      = ir_q[11:9];
  assign rs1     = ir_q[8:6];
  assign rs2     = ir_q[5:3];
  assign imm     = {{(DATA_W-9){1'b0}}, ir_q[8:0]};
  assign is_alu  = op inside {[4'd1:4'd5]};
  assign is_movi = op == 4'd6;
  assign is_ill  = op >= 4'd7;
  assign in_wb   = state_q == WB;
  assign writes  = in_wb && (is_alu || is_movi);
  assign instr_ready = state_q == IDLE;
  assign alu_num1    = num1_q;
  assign alu_num2    = num2_q;
  assign alu_opcode  = opc_q;
  assign wb_valid    = writes;
  assign illegal     = in_wb && is_ill;
  assign wb_addr     = writes ? rd : 3'd0;
  assign wb_data     = writes ? result_q : '0;
  assign zero_flag   = zero_q;
  // Reads the pre-write value while the same register is being written in WB
  assign dbg_data    = rf_q[dbg_addr];
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    num1_d   = num1_q;
    num2_d   = num2_q;
    opc_d    = opc_q;
    result_d = result_q;
    zero_d   = zero_q;
    rf_d     = rf_q;
    case (state_q)
      IDLE: if (instr_valid) begin
        state_d = DECODE;
        ir_d    = instr;
      end
      DECODE: begin
        state_d = EXEC;
        num1_d  = rf_q[rs1];
        num2_d  = rf_q[rs2];
        opc_d   = is_alu ? op : 4'd0;
      end
      EXEC: begin
        state_d  = WB;
        result_d = is_movi ? imm : alu_result;
      end
      default: begin
        state_d = IDLE;
        if (writes) begin
          rf_d[rd] = result_q;
          zero_d   = result_q == '0;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ir_q     <= '0;
      num1_q   <= '0;
      num2_q   <= '0;
      opc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      rf_q     <= '{default: '0};
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      num1_q   <= num1_d;
      num2_q   <= num2_d;
      opc_q    <= opc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      rf_q     <= rf_d;
    end
  end
endmodule
